// File: rtl/sdram_arbit.sv
// Command arbiter for sdram_top: grants one of init/refresh/write/read at a time
// and muxes the owner's command, bank and address onto the SDRAM pins.
module sdram_arbit #(
  parameter int         AREF_MAX_WAIT = 64,
  parameter logic [3:0] CMD_NOP       = 4'b0111
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [11:0] init_addr,
  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [11:0] aref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [11:0] wr_addr,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [11:0] rd_addr,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        wr_brk,
  output logic        rd_brk,
  output logic        aref_late,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_bank,
  output logic [11:0] sdram_addr
);

  // Handshake: an engine holds *_req until it sees its *_en high; it then owns
  // the bus until it pulses *_end for one cycle, after which the arbiter idles.
  typedef enum logic [2:0] {INIT, IDLE, AREF, WRITE, READ} state_t;

  localparam logic [7:0] WAIT_MAX = 8'(AREF_MAX_WAIT);

  state_t     state;
  logic       last_wr;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;

  always_comb begin
    wait_nxt = wait_cnt;
    if (!aref_req || state == AREF)
      wait_nxt = '0;
    else if (wait_cnt != WAIT_MAX)
      wait_nxt = wait_cnt + 8'd1;
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      state     <= INIT;
      last_wr   <= 1'b0;
      wait_cnt  <= '0;
      aref_late <= 1'b0;
      aref_en   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      wr_brk    <= 1'b0;
      rd_brk    <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (wait_nxt == WAIT_MAX)
        aref_late <= 1'b1;
      case (state)
        INIT: begin
          if (init_end)
            state <= IDLE;
        end
        IDLE: begin
          if (aref_req) begin
            state   <= AREF;
            aref_en <= 1'b1;
          end else if (wr_req && (!rd_req || !last_wr)) begin
            state   <= WRITE;
            wr_en   <= 1'b1;
            last_wr <= 1'b1;
          end else if (rd_req) begin
            state   <= READ;
            rd_en   <= 1'b1;
            last_wr <= 1'b0;
          end
        end
        AREF: begin
          if (aref_end) begin
            state   <= IDLE;
            aref_en <= 1'b0;
          end
        end
        WRITE: begin
          if (wr_end) begin
            state  <= IDLE;
            wr_en  <= 1'b0;
            wr_brk <= 1'b0;
          end else if (aref_req) begin
            wr_brk <= 1'b1;
          end
        end
        READ: begin
          if (rd_end) begin
            state  <= IDLE;
            rd_en  <= 1'b0;
            rd_brk <= 1'b0;
          end else if (aref_req) begin
            rd_brk <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          aref_en <= 1'b0;
          wr_en   <= 1'b0;
          rd_en   <= 1'b0;
          wr_brk  <= 1'b0;
          rd_brk  <= 1'b0;
        end
      endcase
    end
  end

  // Pin mux decodes the registered state only, so engine outputs reach the pins unregistered.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_bank = 2'd0;
    sdram_addr = 12'd0;
    case (state)
      INIT: begin
        sdram_cmd  = init_cmd;
        sdram_bank = init_ba;
        sdram_addr = init_addr;
      end
      AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_bank = wr_ba;
        sdram_addr = wr_addr;
      end
      READ: begin
        sdram_cmd  = rd_cmd;
        sdram_bank = rd_ba;
        sdram_addr = rd_addr;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_bank = 2'd0;
        sdram_addr = 12'd0;
      end
    endcase
  end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Command arbiter between the SDRAM init, auto-refresh, write and read engines inside sdram_top.
- Grants exactly one engine at a time and muxes its command, bank and address onto the SDRAM pins.
- Priority: refresh first, then write/read in round-robin.
- Flags an in-progress burst to terminate when a refresh is pending, and records refresh-deadline misses.

Parameters:
AREF_MAX_WAIT, 64, cycles aref_req may stay ungranted before aref_late sets (legal range 2..255)
CMD_NOP, 4'b0111, {cs_n,ras_n,cas_n,we_n} driven when no engine owns the bus

Ports:
sclk  in  1  system clock; all logic on rising edge
srst  in  1  synchronous active-high reset
init_end  in  1  init sequence complete (level or pulse)
init_cmd  in  4  init engine command
init_ba  in  2  init engine bank
init_addr  in  12  init engine address
aref_req  in  1  refresh request, held until granted
aref_end  in  1  1-cycle pulse, refresh done
aref_cmd  in  4  refresh engine command
aref_addr  in  12  refresh engine address
wr_req  in  1  write request, held until granted
wr_end  in  1  1-cycle pulse, write burst done
wr_cmd  in  4  write engine command
wr_ba  in  2  write engine bank
wr_addr  in  12  write engine address
rd_req  in  1  read request, held until granted
rd_end  in  1  1-cycle pulse, read burst done
rd_cmd  in  4  read engine command
rd_ba  in  2  read engine bank
rd_addr  in  12  read engine address
aref_en  out  1  refresh grant
wr_en  out  1  write grant
rd_en  out  1  read grant
wr_brk  out  1  write engine must end its burst at the next boundary
rd_brk  out  1  read engine must end its burst at the next boundary
aref_late  out  1  sticky: refresh waited AREF_MAX_WAIT cycles
sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to SDRAM
sdram_bank  out  2  bank to SDRAM
sdram_addr  out  12  address to SDRAM

Behaviour:
- States: INIT, IDLE, AREF, WRITE, READ; held in a registered state variable.
- Reset (srst=1 at a clock edge):
  - state=INIT; aref_en, wr_en, rd_en, wr_brk, rd_brk, aref_late all 0.
  - Refresh wait counter=0; last_grant=READ, so write wins the first tie.
  - Reset mid-burst aborts immediately; no *_end is awaited.
- INIT:
  - Bus mux selects init_*.
  - init_end=1 -> IDLE next cycle; all requests are ignored until then.
- IDLE:
  - Bus is CMD_NOP, bank 0, address 0.
  - Decision on the sampled requests:
    - aref_req -> AREF.
    - else wr_req&rd_req -> the one not equal to last_grant.
    - else wr_req -> WRITE; else rd_req -> READ; else stay.
  - At least one IDLE cycle always separates two grants.
- Grant signals:
  - Registered: x_en=1 in exactly the cycles where state==X.
  - The first cycle in X is the first cycle x_en is seen high.
  - Entering WRITE or READ updates last_grant.
- AREF / WRITE / READ:
  - Bus mux selects that engine; aref supplies bank 0.
  - Mux is combinational on the registered state: zero added latency from engine outputs to the pins.
  - The matching *_end sampled high -> IDLE next cycle, x_en=0 that cycle.
  - A *_end from a non-owning engine is ignored.
- Brk flags:
  - wr_brk registered: set the cycle after aref_req=1 is sampled while state==WRITE.
  - wr_brk is cleared on the same edge that leaves WRITE.
  - rd_brk is identical for READ.
  - Brk is never asserted outside its state.
- Refresh watchdog:
  - 8-bit counter increments each cycle that aref_req=1 and state!=AREF, saturating at AREF_MAX_WAIT.
  - Counter clears when state==AREF or aref_req=0.
  - Counter reaching AREF_MAX_WAIT sets aref_late, which stays high until srst.
  - The counter still runs during INIT.
- Simultaneous events:
  - aref_req together with wr_end in WRITE -> IDLE, then AREF on the next decision (refresh beats the pending rd_req/wr_req).
  - aref_req together with init_end -> IDLE, then AREF.

Test Plan:
- Reset, then init_end=1 at cycle 10 -> state IDLE at cycle 11; sdram_cmd=4'b0111; all en=0; mux showed init_cmd=4'b0010 during INIT.
- wr_req and rd_req both high in IDLE after reset -> wr_en first. wr_end -> one IDLE cycle, then rd_en. A repeated tie alternates W,R,W,R.
- WRITE active, aref_req rises -> wr_brk=1 the next cycle. wr_end 5 cycles later -> IDLE, then aref_en=1 with rd_req also pending. aref_end -> IDLE, then rd_en.
- In READ, drive rd_cmd=4'b0101, rd_ba=2, rd_addr=12'h3FF -> pins show the same values in the same cycle. Pulse wr_end -> no state change.
- Hold aref_req high with WRITE never ending, AREF_MAX_WAIT=64 -> aref_late=1 after 64 counted cycles. It stays 1 after the later grant, clears only on srst.
- Assert srst during WRITE with wr_brk=1 -> next cycle state INIT, wr_en=0, wr_brk=0, sdram_cmd=init_cmd.
